// File: rtl/bus_mux_seq.sv
// -----------------------------------------------------------------------------
// bus_mux_seq
//   Registered bus source multiplexer with single-transfer and register-dump
//   sequencing and valid/ready output handshake.
//
//   Parameters
//     WIDTH     data width of bus and registers
//     NUM_REGS  number of CPU general registers (>= 2)
//     SEL_W     select width, >= clog2(NUM_REGS+3)
//
//   Ports
//     clk            sole clock, rising edge
//     reset          synchronous active-high reset
//     cpu_reg        general register file contents, cpu_reg[i] is register i
//     din_extended   extended immediate / data-in value  (sel = NUM_REGS)
//     reg_G          ALU result register                  (sel = NUM_REGS+2)
//     sel            source select for a single transfer
//     sel_valid      request one single transfer using sel
//     dump_start     request a dump of cpu_reg[0..NUM_REGS-1] followed by reg_G
//     out_ready      consumer accepts the current beat
//     multiplex_out  registered bus data (held while out_valid=0)
//     out_valid      multiplex_out holds a valid beat
//     out_src        select code of the source of the current beat
//     out_last       current beat is the final (reg_G) beat of a dump
//     sel_err        current beat came from an unmapped sel code
//     busy           state is not IDLE
// -----------------------------------------------------------------------------
module bus_mux_seq #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REGS-1:0][WIDTH-1:0]    cpu_reg,
    input  logic [WIDTH-1:0]                  din_extended,
    input  logic [WIDTH-1:0]                  reg_G,
    input  logic [SEL_W-1:0]                  sel,
    input  logic                              sel_valid,
    input  logic                              dump_start,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  multiplex_out,
    output logic                              out_valid,
    output logic [SEL_W-1:0]                  out_src,
    output logic                              out_last,
    output logic                              sel_err,
    output logic                              busy
);

    // Dump index counts 0..NUM_REGS (NUM_REGS selects reg_G); never wraps.
    localparam int IDX_W = $clog2(NUM_REGS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        DUMP
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic               valid_q, valid_d;
    logic [SEL_W-1:0]   src_q,   src_d;
    logic               last_q,  last_d;
    logic               err_q,   err_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;

    logic               complete;
    logic [WIDTH-1:0]   map_data;
    logic               map_err;
    logic [IDX_W-1:0]   load_idx;
    logic [WIDTH-1:0]   dump_data;
    logic [SEL_W-1:0]   dump_src;
    logic               dump_last;

    assign complete = valid_q && out_ready;

    // Single-transfer source map; unmapped codes give zero data and an error.
    always_comb begin
        map_data = '0;
        map_err  = 1'b1;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (sel == SEL_W'(i)) begin
                map_data = cpu_reg[i];
                map_err  = 1'b0;
            end
        end
        if (sel == SEL_W'(NUM_REGS)) begin
            map_data = din_extended;
            map_err  = 1'b0;
        end
        if (sel == SEL_W'(NUM_REGS + 2)) begin
            map_data = reg_G;
            map_err  = 1'b0;
        end
    end

    // Index of the dump beat that would be loaded at the next edge: the
    // successor while dumping, otherwise beat 0 for a fresh dump accept.
    assign load_idx = (state_q == DUMP) ? idx_q + IDX_W'(1) : '0;

    always_comb begin
        dump_data = reg_G;
        dump_src  = SEL_W'(NUM_REGS + 2);
        dump_last = 1'b1;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (load_idx == IDX_W'(i)) begin
                dump_data = cpu_reg[i];
                dump_src  = SEL_W'(i);
                dump_last = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        src_d   = src_q;
        last_d  = last_q;
        err_d   = err_q;
        idx_d   = idx_q;

        case (state_q)
            DUMP: begin
                if (complete) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d   = load_idx;
                        data_d  = dump_data;
                        src_d   = dump_src;
                        last_d  = dump_last;
                        err_d   = 1'b0;
                    end
                end
            end
            default: begin
                // Accept window: idle, or a single beat completing this edge.
                if (state_q == IDLE || complete) begin
                    if (dump_start) begin
                        state_d = DUMP;
                        idx_d   = '0;
                        data_d  = dump_data;
                        src_d   = dump_src;
                        last_d  = dump_last;
                        err_d   = 1'b0;
                        valid_d = 1'b1;
                    end else if (sel_valid) begin
                        state_d = SINGLE;
                        data_d  = map_data;
                        src_d   = sel;
                        last_d  = 1'b0;
                        err_d   = map_err;
                        valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            last_q  <= last_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    assign multiplex_out = data_q;
    assign out_valid     = valid_q;
    assign out_src       = src_q;
    assign out_last      = last_q;
    assign sel_err       = err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bus_mux_seq.sv
module tb_bus_mux_seq;

    localparam int WIDTH    = 16;
    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 4;

    logic                           clk;
    logic                           reset;
    logic [NUM_REGS-1:0][WIDTH-1:0] cpu_reg;
    logic [WIDTH-1:0]               din_extended;
    logic [WIDTH-1:0]               reg_G;
    logic [SEL_W-1:0]               sel;
    logic                           sel_valid;
    logic                           dump_start;
    logic                           out_ready;
    logic [WIDTH-1:0]               multiplex_out;
    logic                           out_valid;
    logic [SEL_W-1:0]               out_src;
    logic                           out_last;
    logic                           sel_err;
    logic                           busy;

    bus_mux_seq #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_reg       (cpu_reg),
        .din_extended  (din_extended),
        .reg_G         (reg_G),
        .sel           (sel),
        .sel_valid     (sel_valid),
        .dump_start    (dump_start),
        .out_ready     (out_ready),
        .multiplex_out (multiplex_out),
        .out_valid     (out_valid),
        .out_src       (out_src),
        .out_last      (out_last),
        .sel_err       (sel_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               src;
        bit               last;
        bit               err;
    } beat_t;

    beat_t            exp_q[$];
    int               m_srcs[$];
    bit               m_pres;
    bit               m_dumping;
    logic [WIDTH-1:0] m_last_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a transfer is a list of source codes; each code is
    // turned into a beat (value read from the sources at that edge) when the
    // previous beat has been taken.
    function automatic void load_beat(input int src, input bit dump_beat);
        beat_t b;
        b.src = src;
        b.err = 1'b0;
        if (src < NUM_REGS)           b.data = cpu_reg[src];
        else if (src == NUM_REGS)     b.data = din_extended;
        else if (src == NUM_REGS + 2) b.data = reg_G;
        else begin
            b.data = '0;
            b.err  = 1'b1;
        end
        b.last = dump_beat && (m_srcs.size() == 0);
        exp_q.push_back(b);
        m_pres      = 1'b1;
        m_last_data = b.data;
    endfunction

    initial begin
        bit taken;
        m_pres = 0; m_dumping = 0; m_last_data = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_q.delete();
                m_srcs.delete();
                m_pres      = 0;
                m_dumping   = 0;
                m_last_data = '0;
            end else begin
                taken = m_pres && out_ready;
                if (m_dumping) begin
                    if (taken) begin
                        if (m_srcs.size() == 0) begin
                            m_pres    = 0;
                            m_dumping = 0;
                        end else begin
                            load_beat(m_srcs.pop_front(), 1'b1);
                        end
                    end
                end else if (!m_pres || taken) begin
                    if (dump_start) begin
                        m_srcs.delete();
                        for (int i = 0; i < NUM_REGS; i++) m_srcs.push_back(i);
                        m_srcs.push_back(NUM_REGS + 2);
                        m_dumping = 1;
                        load_beat(m_srcs.pop_front(), 1'b1);
                    end else if (sel_valid) begin
                        load_beat(int'(sel), 1'b0);
                    end else begin
                        m_pres = 0;
                    end
                end
            end
        end
    end

    // Monitor: compares every presented beat against the scoreboard head and
    // retires it when the handshake completes.
    initial begin
        beat_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            check("out_valid", 32'(out_valid), 32'(m_pres));
            check("busy", 32'(busy), 32'(m_pres));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("beat_expected", 32'd0, 32'd1);
                end else begin
                    e = exp_q[0];
                    check("beat_data", 32'(multiplex_out), 32'(e.data));
                    check("beat_src",  32'(out_src),       32'(e.src));
                    check("beat_last", 32'(out_last),      32'(e.last));
                    check("beat_err",  32'(sel_err),       32'(e.err));
                    if (out_ready && !reset) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_hold", 32'(multiplex_out), 32'(m_last_data));
            end
        end
    end

    task automatic drive(input bit rst, input bit sv, input int s, input bit ds, input bit rdy);
        @(negedge clk);
        reset      = rst;
        sel_valid  = sv;
        sel        = SEL_W'(s);
        dump_start = ds;
        out_ready  = rdy;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(multiplex_out), 32'd0);
        check({tag, "_valid"}, 32'(out_valid),     32'd0);
        check({tag, "_src"},   32'(out_src),       32'd0);
        check({tag, "_last"},  32'(out_last),      32'd0);
        check({tag, "_err"},   32'(sel_err),       32'd0);
        check({tag, "_busy"},  32'(busy),          32'd0);
    endtask

    initial begin
        bit found;
        reset = 1'b1; sel_valid = 0; sel = '0; dump_start = 0; out_ready = 1;
        for (int i = 0; i < NUM_REGS; i++) cpu_reg[i] = WIDTH'(16'h1000 + i);
        din_extended = 16'hABCD;
        reg_G        = 16'hDEAD;

        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 1);
        check_all_zero("reset");

        // Back-to-back singles, then din_extended, reg_G and an unmapped code.
        for (int i = 0; i < NUM_REGS; i++) drive(0, 1, i, 0, 1);
        drive(0, 1, 8, 0, 1);
        drive(0, 1, 10, 0, 1);
        drive(0, 1, 9, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);

        // Stalled single: source changes and new requests must not disturb it.
        drive(0, 1, 3, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, i, 0, 0);
            cpu_reg[3] = 16'hFFFF;
        end
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        cpu_reg[3] = 16'h1003;
        drive(0, 0, 0, 0, 1);

        // Dump with toggling ready; requests during the dump are ignored.
        drive(0, 0, 0, 1, 1);
        for (int i = 0; i < 24; i++) drive(0, (i % 3) == 0, 8, (i % 5) == 0, (i % 2) == 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1);

        // Simultaneous dump_start and sel_valid in IDLE.
        drive(0, 1, 8, 1, 1);
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 1);

        // Reset in the middle of a dump, then a fresh dump.
        drive(0, 0, 0, 1, 1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_src == SEL_W'(4)) begin
                reset = 1; dump_start = 0; sel_valid = 0; out_ready = 1;
                found = 1;
            end else begin
                reset = 0; dump_start = 0; sel_valid = 0; out_ready = (i % 2) == 0;
            end
        end
        check("dump_beat4_reached", 32'(found), 32'd1);
        drive(0, 0, 0, 0, 1);
        check_all_zero("mid_dump_reset");
        drive(0, 0, 0, 1, 1);
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) cpu_reg[$urandom_range(0, NUM_REGS - 1)] = WIDTH'($urandom);
            if ($urandom_range(0, 7) == 0) din_extended = WIDTH'($urandom);
            if ($urandom_range(0, 7) == 0) reg_G = WIDTH'($urandom);
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 15)), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7);
        end

        // Drain: bounded number of ready cycles with no new requests.
        for (int i = 0; i < 30; i++) drive(0, 0, 0, 0, 1);
        #2;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
